// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment pattern table and frame FSM states
package seg7_pkg;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam int SEG_A  = 7;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;
  typedef enum logic {COLLECT, PULSE} frame_state_e;
endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: active-low segment pattern (a..g) back to BCD with validity flag
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       valid
);
  always_comb begin
    bcd = seg == SEG_0 ? 4'd0 : seg == SEG_1 ? 4'd1 : seg == SEG_2 ? 4'd2 :
          seg == SEG_3 ? 4'd3 : seg == SEG_4 ? 4'd4 : seg == SEG_5 ? 4'd5 :
          seg == SEG_6 ? 4'd6 : seg == SEG_7 ? 4'd7 : seg == SEG_8 ? 4'd8 :
          seg == SEG_9 ? 4'd9 : BCD_BLANK;
    valid = bcd != BCD_BLANK || seg == SEG_BLANK;
  end
endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: debounce and decode a scanned 7-seg display into a digit register file
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int N_DIGITS   = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic [7:0]            seg,
  input  logic [N_DIGITS-1:0]   an,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   dp,
  output logic                  frame_valid,
  output logic                  seg_err,
  output logic                  an_err
);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam logic [3:0] SC = 4'(STABLE_CNT);
  logic ce_q, an_ok, bcd_ok, qual, same, commit;
  logic [7:0] seg_q, last_seg;
  logic [N_DIGITS-1:0] an_q, seen, seen_or, seen_n, commit_mask;
  logic [IW-1:0] idx, last_idx;
  logic [3:0] cnt, cnt_n, bcd;
  frame_state_e state, state_n;
  seg7_to_bcd u_dec (.seg(seg_q[SEG_A:SEG_G]), .bcd(bcd), .valid(bcd_ok));
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_DIGITS; i++)
      if (!an_q[i]) idx = IW'(i);
  end
  assign an_ok = $onehot(~an_q);
  assign qual  = ce_q && an_ok && bcd_ok;
  assign same  = idx == last_idx && seg_q == last_seg;
  assign cnt_n = !ce_q ? cnt : !qual ? 4'd0 : !same ? 4'd1 : cnt == SC ? cnt : cnt + 4'd1;
  // a saturated run must not recommit, but a fresh run reaching SC (SC=1) must
  assign commit      = qual && cnt_n == SC && !(same && cnt == SC);
  assign commit_mask = commit ? N_DIGITS'(1) << idx : '0;
  assign seen_or     = seen | commit_mask;
  always_comb begin
    state_n     = state == COLLECT && &seen_or ? PULSE : COLLECT;
    seen_n      = state == COLLECT && &seen_or ? '0 : seen_or;
    frame_valid = state == PULSE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ce_q     <= 1'b0;
      seg_q    <= '1;
      an_q     <= '1;
      cnt      <= '0;
      last_idx <= '0;
      last_seg <= '0;
      seen     <= '0;
      state    <= COLLECT;
      digits   <= {N_DIGITS{BCD_BLANK}};
      dp       <= '0;
      seg_err  <= 1'b0;
      an_err   <= 1'b0;
    end else begin
      ce_q    <= ce;
      seg_q   <= seg;
      an_q    <= an;
      cnt     <= cnt_n;
      seen    <= seen_n;
      state   <= state_n;
      an_err  <= ce_q && !an_ok;
      seg_err <= ce_q && an_ok && !bcd_ok;
      if (qual) begin
        last_idx <= idx;
        last_seg <= seg_q;
      end
      if (commit) begin
        digits[4*idx +: 4] <= bcd;
        dp[idx]            <= ~seg_q[SEG_DP];
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed checks of scan capture, debounce, errors, ce gating and reset
module tb_seg7_scan_capture;
  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0;
  logic [7:0] seg = 8'hFF;
  logic [3:0] an = 4'hF;
  logic [15:0] digits;
  logic [3:0] dp;
  logic frame_valid, seg_err, an_err;
  int passed = 0, total = 0, fails = 0;
  int fv_cnt = 0, se_cnt = 0, ae_cnt = 0, b_fv, b_se, b_ae;
  logic [7:0] pat [4] = '{8'h9F, 8'h25, 8'h0D, 8'h99};
  always #5 clk = ~clk;
  seg7_scan_capture #(.N_DIGITS(4), .STABLE_CNT(3)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .seg(seg), .an(an), .digits(digits), .dp(dp),
    .frame_valid(frame_valid), .seg_err(seg_err), .an_err(an_err)
  );
  always @(posedge clk) begin
    if (frame_valid) fv_cnt++;
    if (seg_err) se_cnt++;
    if (an_err) ae_cnt++;
  end
  task automatic drive(input logic [7:0] s, input logic [3:0] a, input logic c);
    seg = s;
    an = a;
    ce = c;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) drive(seg, an, 1'b0);
  endtask
  task automatic scan(input int p, input logic tog);
    for (int k = 0; k < 3; k++) begin
      drive(pat[p], 4'(~(4'b1 << p)), 1'b1);
      if (tog) drive(pat[p], 4'(~(4'b1 << p)), 1'b0);
    end
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic snap();
    b_fv = fv_cnt;
    b_se = se_cnt;
    b_ae = ae_cnt;
  endtask
  initial begin
    @(negedge clk);
    idle(2);
    chk("rst_digits", digits, 16'hFFFF);
    chk("rst_dp", 16'(dp), 16'h0);
    chk("rst_fv", 16'(frame_valid), 16'h0);
    chk("rst_seg_err", 16'(seg_err), 16'h0);
    chk("rst_an_err", 16'(an_err), 16'h0);
    rst_n = 1'b1;
    snap();
    for (int p = 0; p < 4; p++) scan(p, 1'b0);
    idle(2);
    chk("scan_digits", digits, 16'h4321);
    chk("scan_dp", 16'(dp), 16'h0);
    chk("scan_frames", 16'(fv_cnt - b_fv), 16'd1);
    chk("scan_seg_err", 16'(se_cnt - b_se), 16'd0);
    chk("scan_an_err", 16'(ae_cnt - b_ae), 16'd0);
    drive(8'h49, 4'b1110, 1'b1);
    drive(8'h49, 4'b1110, 1'b1);
    drive(8'h1F, 4'b1110, 1'b1);
    idle(2);
    chk("two_then_change", digits, 16'h4321);
    drive(8'h1F, 4'b1110, 1'b1);
    drive(8'h1F, 4'b1110, 1'b1);
    chk("third_not_yet", digits, 16'h4321);
    idle(1);
    chk("third_commit", digits, 16'h4327);
    for (int k = 0; k < 3; k++) drive(8'hFE, 4'b1101, 1'b1);
    idle(2);
    chk("blank_digits", digits, 16'h43F7);
    chk("blank_dp", 16'(dp), 16'h2);
    snap();
    drive(8'h6D, 4'b1011, 1'b1);
    idle(1);
    chk("seg_err_pulse", 16'(seg_err), 16'h1);
    chk("seg_err_no_an", 16'(an_err), 16'h0);
    idle(1);
    chk("seg_err_clear", 16'(seg_err), 16'h0);
    drive(8'h6D, 4'b1011, 1'b1);
    drive(8'h6D, 4'b1011, 1'b1);
    idle(2);
    chk("seg_err_count", 16'(se_cnt - b_se), 16'd3);
    chk("seg_err_digits", digits, 16'h43F7);
    drive(8'h0D, 4'b1100, 1'b1);
    idle(1);
    chk("an_err_pulse", 16'(an_err), 16'h1);
    chk("an_err_no_seg", 16'(seg_err), 16'h0);
    drive(8'h6D, 4'b1111, 1'b1);
    idle(2);
    chk("an_err_count", 16'(ae_cnt - b_ae), 16'd2);
    chk("an_err_seg_count", 16'(se_cnt - b_se), 16'd3);
    chk("err_digits", digits, 16'h43F7);
    chk("err_dp", 16'(dp), 16'h2);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    chk("rst2_digits", digits, 16'hFFFF);
    snap();
    for (int p = 0; p < 3; p++) scan(p, 1'b1);
    idle(2);
    chk("ce_partial_digits", digits, 16'hF321);
    chk("ce_partial_frames", 16'(fv_cnt - b_fv), 16'd0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    chk("mid_rst_digits", digits, 16'hFFFF);
    scan(3, 1'b1);
    idle(2);
    chk("after_rst_one", digits, 16'h4FFF);
    chk("after_rst_frames", 16'(fv_cnt - b_fv), 16'd0);
    for (int p = 0; p < 4; p++) scan(p, 1'b1);
    idle(2);
    chk("ce_full_digits", digits, 16'h4321);
    chk("ce_full_frames", 16'(fv_cnt - b_fv), 16'd1);
    chk("ce_full_errs", 16'(se_cnt - b_se + ae_cnt - b_ae), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
